// File: rtl/ciphertext_framer.sv
// ciphertext_framer
//   Receive-side framing buffer for the SPI ciphertext link. 32-bit blocks
//   arrive least-significant first; every NUM_BLOCKS of them form one
//   ciphertext. Two ciphertexts are held in a ping-pong buffer (slot 0/1) and
//   each is replayed block by block under a consume handshake. Frames that
//   arrive while no slot is free are counted off and dropped so that later
//   frames stay aligned.
//
//   Optional feature (macro CIPHER_FRAMER_TIMEOUT_EN): an idle counter that
//   discards a partial frame after TIMEOUT_CYCLES cycles without a block.
//   With the macro undefined, timeout_out is tied to 0 and a partial frame
//   waits indefinitely.
//
// Ports
//   clk_in, rst_in     clock, synchronous active-high reset
//   data_in, valid_in  incoming block and its one-cycle strobe
//   consumed_in        downstream has taken the presented block
//   data_out, valid_out presented block (held stable while valid)
//   frame_start_out    valid_out on block 0 of a frame
//   frame_end_out      valid_out on block NUM_BLOCKS-1
//   frame_count_out    frames fully delivered (wraps at 2^16)
//   overflow_out       sticky: a frame was dropped for lack of a slot
//   timeout_out        one-cycle pulse when a partial frame is timed out
module ciphertext_framer #(
    parameter int REGISTER_SIZE  = 32,
    parameter int BITS_IN_NUM    = 4096,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [REGISTER_SIZE-1:0] data_in,
    input  logic                     valid_in,
    input  logic                     consumed_in,
    output logic [REGISTER_SIZE-1:0] data_out,
    output logic                     valid_out,
    output logic                     frame_start_out,
    output logic                     frame_end_out,
    output logic [15:0]              frame_count_out,
    output logic                     overflow_out,
    output logic                     timeout_out
);

    localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
    localparam int IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int ADDR_W     = $clog2(2 * NUM_BLOCKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

    if ((BITS_IN_NUM % REGISTER_SIZE) != 0 || BITS_IN_NUM < REGISTER_SIZE) begin : g_bad_size
        $error("BITS_IN_NUM must be a non-zero multiple of REGISTER_SIZE");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic {W_FILL, W_DISCARD} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_PRESENT, R_GAP} rd_state_e;

    // Slot 0 occupies words [0, NUM_BLOCKS), slot 1 the next NUM_BLOCKS.
    function automatic logic [ADDR_W-1:0] addr_of(input logic slot, input logic [IDX_W-1:0] idx);
        return slot ? (ADDR_W'(NUM_BLOCKS) + ADDR_W'(idx)) : ADDR_W'(idx);
    endfunction

    // Storage has no reset: contents are only reachable through a ready flag,
    // and the flags are cleared by reset.
    logic [REGISTER_SIZE-1:0] mem_q [2*NUM_BLOCKS];

    wr_state_e  wr_state_q, wr_state_d;
    logic       wr_slot_q, wr_slot_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [1:0] ready_q, ready_d;
    logic       overflow_q, overflow_d;
    logic       mem_we;
    logic [1:0] set_ready;

    rd_state_e  rd_state_q, rd_state_d;
    logic       rd_slot_q, rd_slot_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [1:0] clr_ready;
    logic       rd_load;
    logic [15:0] frame_count_q, frame_count_d;
    logic [REGISTER_SIZE-1:0] data_out_q, data_out_d;
    logic       valid_out_q, valid_out_d;
    logic       start_q, start_d;
    logic       end_q, end_d;

`ifdef CIPHER_FRAMER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
    logic            timeout_q, timeout_d;
    logic            idle_active;
`endif

    // ------------------------------------------------------------------
    // Write FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_state_d = wr_state_q;
        wr_slot_d  = wr_slot_q;
        wr_idx_d   = wr_idx_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        set_ready  = 2'b00;
        case (wr_state_q)
            W_FILL: begin
                if (valid_in) begin
                    // A slot's ready flag stays set until its last block is
                    // consumed, so it also covers "slot currently being read".
                    if (wr_idx_q == '0 && ready_q[wr_slot_q]) begin
                        overflow_d = 1'b1;
                        // The dropped block is the first of the discarded frame.
                        wr_state_d = (NUM_BLOCKS > 1) ? W_DISCARD : W_FILL;
                        wr_idx_d   = (NUM_BLOCKS > 1) ? IDX_W'(1) : '0;
                    end else begin
                        mem_we = 1'b1;
                        if (wr_idx_q == LAST_IDX) begin
                            set_ready[wr_slot_q] = 1'b1;
                            wr_slot_d = ~wr_slot_q;
                            wr_idx_d  = '0;
                        end else begin
                            wr_idx_d = wr_idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            W_DISCARD: begin
                // wr_idx counts blocks of the dropped frame
                if (valid_in) begin
                    if (wr_idx_q == LAST_IDX) begin
                        wr_state_d = W_FILL;
                        wr_idx_d   = '0;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end
            default: wr_state_d = W_FILL;
        endcase

`ifdef CIPHER_FRAMER_TIMEOUT_EN
        idle_active = (wr_state_q == W_DISCARD) || (wr_idx_q != '0);
        timeout_d   = 1'b0;
        if (valid_in || !idle_active) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the partial frame; ready flags are left alone.
            idle_cnt_d = '0;
            wr_state_d = W_FILL;
            wr_idx_d   = '0;
            timeout_d  = 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q + TO_W'(1);
        end
`endif
    end

    // ------------------------------------------------------------------
    // Read FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_slot_d     = rd_slot_q;
        rd_idx_d      = rd_idx_q;
        clr_ready     = 2'b00;
        rd_load       = 1'b0;
        frame_count_d = frame_count_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ready_q[rd_slot_q]) begin
                    rd_state_d = R_PRESENT;
                    rd_load    = 1'b1;
                end
            end
            R_PRESENT: begin
                if (consumed_in) begin
                    if (rd_idx_q == LAST_IDX) begin
                        clr_ready[rd_slot_q] = 1'b1;
                        rd_slot_d     = ~rd_slot_q;
                        rd_idx_d      = '0;
                        frame_count_d = frame_count_q + 16'd1;
                        rd_state_d    = R_IDLE;
                    end else begin
                        rd_idx_d   = rd_idx_q + IDX_W'(1);
                        rd_state_d = R_GAP;
                    end
                end
            end
            R_GAP: begin
                // rd_idx already points at the next block
                rd_state_d = R_PRESENT;
                rd_load    = 1'b1;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read FSM: registered outputs, decoded from the next state
    // ------------------------------------------------------------------
    always_comb begin
        data_out_d  = rd_load ? mem_q[addr_of(rd_slot_q, rd_idx_q)] : data_out_q;
        valid_out_d = (rd_state_d == R_PRESENT);
        start_d     = valid_out_d && (rd_idx_d == '0);
        end_d       = valid_out_d && (rd_idx_d == LAST_IDX);
    end

    // Writer only sets a flag on a slot that is not ready and the reader only
    // clears a ready one, so both can act in the same cycle.
    always_comb begin
        ready_d = (ready_q & ~clr_ready) | set_ready;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem_q[addr_of(wr_slot_q, wr_idx_q)] <= data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_state_q    <= W_FILL;
            wr_slot_q     <= 1'b0;
            wr_idx_q      <= '0;
            ready_q       <= 2'b00;
            overflow_q    <= 1'b0;
            rd_state_q    <= R_IDLE;
            rd_slot_q     <= 1'b0;
            rd_idx_q      <= '0;
            frame_count_q <= '0;
            data_out_q    <= '0;
            valid_out_q   <= 1'b0;
            start_q       <= 1'b0;
            end_q         <= 1'b0;
        end else begin
            wr_state_q    <= wr_state_d;
            wr_slot_q     <= wr_slot_d;
            wr_idx_q      <= wr_idx_d;
            ready_q       <= ready_d;
            overflow_q    <= overflow_d;
            rd_state_q    <= rd_state_d;
            rd_slot_q     <= rd_slot_d;
            rd_idx_q      <= rd_idx_d;
            frame_count_q <= frame_count_d;
            data_out_q    <= data_out_d;
            valid_out_q   <= valid_out_d;
            start_q       <= start_d;
            end_q         <= end_d;
        end
    end

`ifdef CIPHER_FRAMER_TIMEOUT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
    assign timeout_out = timeout_q;
`else
    assign timeout_out = 1'b0;
`endif

    assign data_out        = data_out_q;
    assign valid_out       = valid_out_q;
    assign frame_start_out = start_q;
    assign frame_end_out   = end_q;
    assign frame_count_out = frame_count_q;
    assign overflow_out    = overflow_q;

endmodule

// File: doc/ciphertext_framer.md
# ciphertext_framer

Receive-side framing buffer for the SPI ciphertext link. It accepts the 32-bit blocks recovered by the SPI peripheral (`spi_pe`), least-significant block first, and groups every `BITS_IN_NUM/REGISTER_SIZE` blocks into one ciphertext. It holds up to two complete ciphertexts in a ping-pong buffer and replays each one, block by block, to the downstream consumer (`byte_repeater` or the decryptor datapath) under a consume handshake. Partial, overflowing or stalled frames are discarded so that later frames stay aligned.

## Interface
Parameters:
- `REGISTER_SIZE`, 32: block width in bits.
- `BITS_IN_NUM`, 4096: ciphertext width in bits. Must be a multiple of `REGISTER_SIZE`. `NUM_BLOCKS = BITS_IN_NUM/REGISTER_SIZE`.
- `TIMEOUT_CYCLES`, 100000: idle-gap limit inside a partial frame. Used only with `CIPHER_FRAMER_TIMEOUT_EN`.

Ports:
- `clk_in`, in, 1: single system clock.
- `rst_in`, in, 1: reset, synchronous, active-high.
- `data_in`, in, `REGISTER_SIZE`: incoming block.
- `valid_in`, in, 1: one-cycle pulse marking each `data_in` block.
- `consumed_in`, in, 1: downstream has taken the currently presented block.
- `data_out`, out, `REGISTER_SIZE`: presented block.
- `valid_out`, out, 1: `data_out` is valid.
- `frame_start_out`, out, 1: asserted with `valid_out` on block 0 of a frame.
- `frame_end_out`, out, 1: asserted with `valid_out` on block `NUM_BLOCKS-1`.
- `frame_count_out`, out, 16: number of frames fully delivered. Wraps at 2^16.
- `overflow_out`, out, 1: sticky; set when any frame was dropped because no slot was free.
- `timeout_out`, out, 1: one-cycle pulse when a partial frame is discarded on timeout.

## Operation
- **Storage:** `2*NUM_BLOCKS` words, organised as slot 0 and slot 1. Each slot has a ready flag.
- **Write FSM: W_FILL**
  - On each `valid_in`, store the block at `wr_slot`, index `wr_idx`, then increment `wr_idx`.
  - When the block at index `NUM_BLOCKS-1` is written, set ready on `wr_slot`, toggle `wr_slot` and clear `wr_idx`.
  - If `valid_in` arrives with `wr_idx==0` while `wr_slot` is ready or being read, set `overflow_out`, drop the block and enter W_DISCARD.
- **Write FSM: W_DISCARD**
  - Count incoming blocks without storing them.
  - Return to W_FILL with `wr_idx=0` after `NUM_BLOCKS` blocks of the dropped frame have been counted.
- **Read FSM: R_IDLE**
  - If the ready flag of `rd_slot` is set, load block 0 into `data_out` and go to R_PRESENT.
- **Read FSM: R_PRESENT**
  - `valid_out=1` and `data_out` is held stable.
  - On `consumed_in`, advance `rd_idx` and go to R_GAP.
  - If the consumed block was the last one: clear ready on `rd_slot`, toggle `rd_slot`, clear `rd_idx`, increment `frame_count_out`, then go to R_IDLE instead of R_GAP.
- **Read FSM: R_GAP**
  - `valid_out=0` for one cycle while the registered read is issued, then return to R_PRESENT.
- **Ignored inputs:** `consumed_in` while `valid_out=0` has no effect.
- **Simultaneous events:**
  - A write completing a frame and a read retiring the last block of the other slot in the same cycle are both honoured.
  - The read side may reach R_PRESENT on the newly ready slot no earlier than the next cycle.
- **Reset:**
  - Mid-operation reset clears all slots, flags, indices and counters. Partial and buffered frames are lost.
  - Both FSMs restart in W_FILL and R_IDLE with `wr_slot=rd_slot=0`.

## Timing
- **Reset values:** `data_out=0`, `valid_out=0`, `frame_start_out=0`, `frame_end_out=0`, `frame_count_out=0`, `overflow_out=0`, `timeout_out=0`.
- **Frame latency:** if the last block's `valid_in` is in cycle t and the reader is idle, block 0 is presented with `valid_out=1` at t+2.
- **Block-to-block cadence:** for `consumed_in` in cycle t, `valid_out=0` at t+1 and the next block is valid at t+2. Maximum read rate is one block per 2 cycles.
- **Input rate:** `valid_in` is accepted every cycle. No input backpressure exists; the only defence against a full buffer is to drop.
- All outputs are registered.

## Configuration
- **Macro:** `CIPHER_FRAMER_TIMEOUT_EN`.
- **Defined:**
  - An idle counter runs while the write FSM is in W_FILL with `wr_idx!=0`, or in W_DISCARD. It resets on every `valid_in`.
  - When the counter reaches `TIMEOUT_CYCLES`, the partial frame is discarded, `wr_idx` is cleared, the FSM goes to W_FILL and `timeout_out` pulses for one cycle.
  - Slot ready flags are untouched by a timeout.
- **Undefined:**
  - No idle counter exists and `timeout_out` is tied to 0.
  - A partial frame waits indefinitely for its remaining blocks.

## Test plan
Bench parameters: `BITS_IN_NUM=128`, `REGISTER_SIZE=32` (4 blocks per frame), `TIMEOUT_CYCLES=20`.
- **Single frame:** send blocks 0x11, 0x22, 0x33, 0x44 back-to-back, with `consumed_in` asserted each cycle `valid_out` is high -> output is 0x11 (start), 0x22, 0x33, 0x44 (end), each separated by one gap cycle; `frame_count_out=1`.
- **Buffer fill then overflow:** send 3 frames while holding `consumed_in=0` -> frames 1 and 2 are buffered, frame 3 is dropped and `overflow_out=1`. Release `consumed_in` -> frames 1 and 2 are output intact; `frame_count_out=2`.
- **Alignment after drop:** after the overflow case, send frame 4 = 0xA0..0xA3 -> it is output exactly as sent, starting with 0xA0 and `frame_start_out` asserted.
- **Timeout (macro defined):** send 2 blocks, then idle 20 cycles -> one `timeout_out` pulse. Then send a full frame of 0xB0..0xB3 -> it is output correctly and nothing is output for the discarded pair.
- **Reset mid-operation:** one frame buffered and block 1 presented, then assert `rst_in` for 1 cycle -> every output returns to its reset value on the next cycle. A subsequent frame is delivered starting from slot 0.
- **Coincident write/read:** the last `valid_in` of frame 2 lands in the same cycle as the `consumed_in` of frame 1's last block -> frame 2 block 0 is presented no earlier than the next cycle, and nothing is lost or duplicated.
